// File: rtl/reg_file20_pkg.sv
// ---------------------------------------------------------------------------
// flow_pkg: shared types and sizes for the flow-control datapath.
//   WORD_W     : data word width (20)
//   NREG       : number of architectural registers (32)
//   REG_ADDR_W : register address width, log2(NREG)
//   word_t     : one data word
//   reg_addr_t : one register address
// ---------------------------------------------------------------------------
package flow_pkg;

  localparam int WORD_W     = 20;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : flow_pkg

// File: rtl/reg_file20_if.sv
// ---------------------------------------------------------------------------
// reg_file20_if: bus bundle for the register file.
//   wr_en/wr_addr/wr_data           : write port (steered write data)
//   rd_en_x/rd_addr_x               : read request, ports A and B
//   rd_data_x/rd_valid_x            : registered read response, ports A and B
//   written                         : per-register "written since reset" map
// Modports:
//   master : the requester (routing / source-select logic, testbench)
//   slave  : the register file
// ---------------------------------------------------------------------------
interface reg_file20_if;
  import flow_pkg::*;

  logic              wr_en;
  reg_addr_t         wr_addr;
  word_t             wr_data;

  logic              rd_en_a;
  reg_addr_t         rd_addr_a;
  word_t             rd_data_a;
  logic              rd_valid_a;

  logic              rd_en_b;
  reg_addr_t         rd_addr_b;
  word_t             rd_data_b;
  logic              rd_valid_b;

  logic [NREG-1:0]   written;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, written
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, written
  );

endinterface : reg_file20_if

// File: rtl/reg_file20_read_port.sv
// ---------------------------------------------------------------------------
// reg_read_port: one registered read port of the register file.
//   clk, rst_n       : clock, asynchronous active-low reset
//   rd_en, rd_addr   : read request
//   wr_en, wr_addr,
//   wr_data          : current write, used for write-first bypass
//   mem              : flattened view of the storage array
//   rd_data          : registered read data (holds when rd_en=0)
//   rd_valid         : high for one cycle after each accepted read
// ---------------------------------------------------------------------------
module reg_read_port
  import flow_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_en,
  input  reg_addr_t                   rd_addr,
  input  logic                        wr_en,
  input  reg_addr_t                   wr_addr,
  input  word_t                       wr_data,
  input  logic [NREG-1:0][WORD_W-1:0] mem,
  output word_t                       rd_data,
  output logic                        rd_valid
);

  word_t rd_data_q, rd_data_d;
  logic  rd_valid_q, rd_valid_d;
  word_t rd_value;

  always_comb begin
    // Register 0 wins over the bypass so a discarded write to 0 never leaks.
    rd_value = mem[rd_addr];
    if (rd_addr == '0) begin
      rd_value = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_value = wr_data;
    end

    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      rd_data_d = rd_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule : reg_read_port

// File: rtl/reg_file20.sv
// ---------------------------------------------------------------------------
// reg_file20: 32 x 20-bit register file, one write port, two registered
// read ports with write-first bypass, hardwired-zero register 0 and a
// per-register "written" bitmap.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset, clears storage and outputs
//   bus   : reg_file20_if.slave (write port, read ports A/B, written map)
// Storage is a flop array so the whole file clears on asynchronous reset.
// ---------------------------------------------------------------------------
module reg_file20
  import flow_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  reg_file20_if.slave bus
);

  logic [NREG-1:0][WORD_W-1:0] mem_q, mem_d;
  logic [NREG-1:0]             written_q, written_d;
  logic                        wr_accept;

  word_t rd_data_a, rd_data_b;
  logic  rd_valid_a, rd_valid_b;

  // Writes to register 0 are dropped entirely, so entry 0 and written[0]
  // are never updated from reset.
  assign wr_accept = bus.wr_en && (bus.wr_addr != '0);

  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    if (wr_accept) begin
      mem_d[bus.wr_addr]     = bus.wr_data;
      written_d[bus.wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      written_q <= '0;
    end else begin
      mem_q     <= mem_d;
      written_q <= written_d;
    end
  end

  reg_read_port u_port_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (bus.rd_en_a),
    .rd_addr  (bus.rd_addr_a),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .mem      (mem_q),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a)
  );

  reg_read_port u_port_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (bus.rd_en_b),
    .rd_addr  (bus.rd_addr_b),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .mem      (mem_q),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b)
  );

  assign bus.rd_data_a  = rd_data_a;
  assign bus.rd_valid_a = rd_valid_a;
  assign bus.rd_data_b  = rd_data_b;
  assign bus.rd_valid_b = rd_valid_b;
  assign bus.written    = written_q;

endmodule : reg_file20

// File: doc/reg_file20.md
# reg_file20

Register file holding 32 words of 20 bits, with one synchronous write port and two registered read ports. It sits between the flow-control routing logic, taking write data that has already been steered by a destination select, and the source-select stage that picks operands. It adds storage, write-first bypass, a hardwired-zero register 0, and a per-register "written" bitmap for debug and verification.

## Interface
- WIDTH, 20, data word width
- DEPTH, 32, number of registers
- ADDR_W, 5, address width, equal to log2(DEPTH)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous reset, active-low
- wr_en  in  1  write request, sampled at posedge
- wr_addr  in  ADDR_W  destination register
- wr_data  in  WIDTH  write data
- rd_en_a  in  1  read request, port A
- rd_addr_a  in  ADDR_W  source register, port A
- rd_data_a  out  WIDTH  registered read data, port A
- rd_valid_a  out  1  pulses high one cycle after an accepted read on port A
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b  same as port A, for port B
- written  out  DEPTH  bit i is set once register i has been written since reset; bit 0 is always 0

## Operation
- Write:
  - at posedge, if wr_en=1 and wr_addr≠0, then mem[wr_addr] <= wr_data and written[wr_addr] <= 1.
  - A write to address 0 is discarded: no state change and written[0] stays 0.
- Read, each port independent:
  - at posedge, if rd_en=1, then rd_data <= value and rd_valid <= 1.
  - If rd_en=0, rd_valid <= 0 and rd_data holds its previous value.
- Read value, in priority order:
  - rd_addr=0 gives 0.
  - Otherwise, if wr_en=1 and wr_addr=rd_addr at the same edge, the value is wr_data (write-first bypass).
  - Otherwise the value is mem[rd_addr].
- Both ports may read the same address in the same cycle. Each gets the identical value, including the bypass.
- No back-pressure: every request is accepted in the cycle it is presented.
- Width: all data paths are exactly WIDTH bits. There is no sign or extension logic, and addresses never exceed DEPTH-1.

## Timing
- Read latency is 1 cycle: a request at edge N produces data and valid at edge N, visible during cycle N+1.
- A write at edge N is visible to:
  - a read sampled at edge N, through the bypass;
  - every later read, through storage.
- Back-to-back reads every cycle give rd_valid high continuously with new data each cycle.
- Reset values while rst_n=0, taking effect immediately without waiting for a clock:
  - all mem = 0
  - rd_data_a/b = 0
  - rd_valid_a/b = 0
  - written = 0
- Reset asserted mid-operation: any read in flight is lost, and rd_valid drops asynchronously.
- First edge after rst_n deasserts: normal operation, with requests sampled at that edge honoured.
- Simultaneous write and both reads to the same address: both ports return wr_data, and storage is updated.
- Address wrap: none. ADDR_W bits always index inside DEPTH=32.

## Structure
- Shared package flow_pkg holds:
  - localparams WORD_W=20, NREG=32, REG_ADDR_W=5;
  - typedef word_t (logic [WORD_W-1:0]);
  - typedef reg_addr_t.
- Sub-module reg_read_port, instantiated twice. It contains the zero check, bypass compare, array select, and the rd_data/rd_valid flops. The top level holds the storage array, write decode and the written bitmap.
- Storage is a flop array, not an inferred RAM, because of the asynchronous reset.

## Test plan
- Reset then idle:
  - stimulus: hold rst_n=0 for 3 cycles and release; read addresses 0, 1 and 31 on port A.
  - required: rd_data_a=0 each time, rd_valid_a high one cycle after each request, written=0.
- Write/read all:
  - stimulus: write wr_data=i to address i for i=0..31, then read every address on port A and 31-i on port B.
  - required: A returns i (0 for address 0) and B returns 31-i (0 when 31-i=0).
  - required: written=32'hFFFF_FFFE at the end.
- Bypass:
  - stimulus: at the same edge, wr_addr=5 with wr_data=20'hABCDE, and rd_addr_a=rd_addr_b=5.
  - required: both ports return 20'hABCDE on the next cycle.
- Register 0:
  - stimulus: write 20'hFFFFF to address 0 while both ports read address 0.
  - required: both ports return 0 and written[0]=0.
- Hold:
  - stimulus: read address 3 holding 20'h00003, then drop rd_en_a for 4 cycles while writing 20'h00009 to address 3.
  - required: rd_data_a stays 20'h00003 and rd_valid_a=0 during those cycles.
- Async reset mid-stream:
  - stimulus: assert rst_n=0 between clock edges while rd_valid_a=1.
  - required: rd_valid_a, rd_data_a and written clear before the next edge.
  - required: a read of address 7 after release returns 0.
